// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds op encodings, the 3-bit FSM state encoding and the cycle-count constants
// used by muldiv_seq_ctrl and its testbench.
package muldiv_pkg;

  typedef logic [1:0] op_t;

  // Op encodings: bit 1 selects divide, bit 0 selects signed.
  localparam op_t OpMultu = 2'b00;
  localparam op_t OpMult  = 2'b01;
  localparam op_t OpDivu  = 2'b10;
  localparam op_t OpDiv   = 2'b11;

  // FSM state encoding.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre0  = 3'd1;
  localparam logic [2:0] StPre1  = 3'd2;
  localparam logic [2:0] StIter  = 3'd3;
  localparam logic [2:0] StPost0 = 3'd4;
  localparam logic [2:0] StPost1 = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam int unsigned Iters      = 32;
  localparam int unsigned PreCycles  = 2;
  localparam int unsigned PostCycles = 2;

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Request/result bundle of the multiply/divide unit.
// master: requester (drives start/op/a/b, receives busy/done/hi/lo/dz).
// slave:  muldiv_seq_ctrl.
interface muldiv_seq_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  modport master (output start, op, a, b, input busy, done, hi, lo, dz);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/adder_32bit.sv
// 32-bit adder with carry in, shared by every pass of the multiply/divide unit.
// Ports: a_i, b_i operands; ci_i carry in; sum_o result; cf_o carry out;
//        of_o signed overflow.
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] sum_o,
  output logic        cf_o,
  output logic        of_o
);
  logic [32:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i} + {32'd0, ci_i};
  assign sum_o = full[31:0];
  assign cf_o  = full[32];
  assign of_o  = (a_i[31] == b_i[31]) && (sum_o[31] != a_i[31]);
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle multiply/divide unit for the HI/LO path.
// Drives one shared adder through shift-add multiply and restoring divide;
// signed ops get abs() passes before and negation passes after the iterations.
// Ports: clk, rst (synchronous, active high); bus (slave modport): start, op, a, b in;
//        busy, done, hi, lo, dz out.
// Build option: MULDIV_DZ_FAST_EN makes a divide by zero finish in one cycle.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumIters  = Iters
) (
  input logic               clk,
  input logic               rst,
  muldiv_seq_ctrl_if.slave  bus
);

  logic [2:0]           state_q, state_d;
  op_t                  op_q, op_d;
  logic [DataWidth-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 sa_q, sa_d, sb_q, sb_d, carry_q, carry_d, dz_q, dz_d;

  logic [DataWidth-1:0] add_a, add_b, sum, rem_sh, quo_sh;
  logic                 add_ci, cf, unused_of;
  logic                 is_div, neg_res, msb_out;

  assign is_div  = op_is_div(op_q);
  assign neg_res = sa_q ^ sb_q;
  // Divide step view of {hi,lo} shifted left by one.
  assign msb_out = hi_q[DataWidth-1];
  assign rem_sh  = {hi_q[DataWidth-2:0], lo_q[DataWidth-1]};
  assign quo_sh  = {lo_q[DataWidth-2:0], 1'b0};

  adder_32bit u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .ci_i  (add_ci),
    .sum_o (sum),
    .cf_o  (cf),
    .of_o  (unused_of)
  );

  // Adder operand selection per state.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      StPre0: begin
        add_a  = a_q[DataWidth-1] ? ~a_q : a_q;
        add_ci = a_q[DataWidth-1];
      end
      StPre1: begin
        add_a  = b_q[DataWidth-1] ? ~b_q : b_q;
        add_ci = b_q[DataWidth-1];
      end
      StIter: begin
        if (is_div) begin
          add_a  = rem_sh;
          add_b  = ~b_q;
          add_ci = 1'b1;
        end else begin
          add_a = hi_q;
          add_b = lo_q[0] ? a_q : '0;
        end
      end
      StPost0: begin
        add_a  = neg_res ? ~lo_q : lo_q;
        add_ci = neg_res;
      end
      StPost1: begin
        // Divide: remainder takes the dividend's sign. Multiply: finish the
        // 64-bit negate using the carry out of the low word.
        if (is_div ? sa_q : neg_res) begin
          add_a  = ~hi_q;
          add_ci = is_div ? 1'b1 : carry_q;
        end else begin
          add_a = hi_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          sa_d    = op_is_signed(bus.op) & bus.a[DataWidth-1];
          sb_d    = op_is_signed(bus.op) & bus.b[DataWidth-1];
          hi_d    = '0;
          lo_d    = op_is_div(bus.op) ? bus.a : bus.b;
          cnt_d   = '0;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          state_d = op_is_signed(bus.op) ? StPre0 : StIter;
`ifdef MULDIV_DZ_FAST_EN
          if (op_is_div(bus.op) && (bus.b == '0)) begin
            hi_d    = bus.a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StPre0: begin
        a_d     = sum;
        state_d = StPre1;
      end
      StPre1: begin
        b_d     = sum;
        hi_d    = '0;
        lo_d    = is_div ? a_q : sum;
        state_d = StIter;
      end
      StIter: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div) begin
          // Restoring step: keep the difference only if it did not go negative.
          if (msb_out | cf) begin
            hi_d = sum;
            lo_d = {quo_sh[DataWidth-1:1], 1'b1};
          end else begin
            hi_d = rem_sh;
            lo_d = quo_sh;
          end
        end else begin
          hi_d = {cf, sum[DataWidth-1:1]};
          lo_d = {sum[0], lo_q[DataWidth-1:1]};
        end
        if (cnt_q == 5'(NumIters - 1)) begin
          dz_d    = is_div && (b_q == '0);
          state_d = op_is_signed(op_q) ? StPost0 : StDone;
        end
      end
      StPost0: begin
        lo_d    = sum;
        carry_d = cf;
        state_d = StPost1;
      end
      StPost1: begin
        hi_d    = sum;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpMultu;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Testbench for muldiv_seq_ctrl: directed ops, an arithmetic reference model checked
// every cycle, and literal expectations from hand calculation.
module tb_muldiv_seq_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_seq_ctrl_if bus ();

  muldiv_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  logic rst_hit = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_hit <= rst;
  end

  // Expectation of the op in flight (written by the driver only).
  bit          m_act = 1'b0;
  int          m_acc = -100;
  int          m_lat = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0, m_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic checkb(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, want %b (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output logic chk, output int lat);
    logic [63:0]        p;
    logic signed [63:0] sa, sb, sp;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    dz  = op[1] && (b == 32'd0);
    chk = 1'b1;
    lat = op[0] ? 37 : 33;
    hi  = '0;
    lo  = '0;
    case (op)
      OpMultu: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      OpMult: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OpDivu: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: begin
        if (b == 32'd0) chk = 1'b0;
        else begin
          sp = sa / sb;
          lo = sp[31:0];
          sp = sa % sb;
          hi = sp[31:0];
        end
      end
    endcase
`ifdef MULDIV_DZ_FAST_EN
    if (dz) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      chk = 1'b1;
      lat = 1;
    end
`endif
  endfunction

  // Per-cycle compare against the model.
  int          killed_acc = -1000;
  logic [31:0] h_hi = '0, h_lo = '0;
  logic        h_dz = 1'b0, h_chk = 1'b1;

  always @(negedge clk) begin
    int   n;
    logic e_busy, e_done;
    if (cyc > 0) begin
      if (rst_hit) begin
        killed_acc = m_acc;
        h_hi = '0;
        h_lo = '0;
        h_dz = 1'b0;
        h_chk = 1'b1;
      end
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_act && (m_acc != killed_acc)) begin
        n      = cyc - m_acc;
        e_busy = (n >= 1) && (n <= m_lat);
        e_done = (n == m_lat);
      end
      checkb("busy", bus.busy, e_busy);
      checkb("done", bus.done, e_done);
      if (e_done) begin
        h_hi  = m_hi;
        h_lo  = m_lo;
        h_dz  = m_dz;
        h_chk = m_chk;
      end
      if (!e_busy || e_done) begin
        checkb("dz", bus.dz, h_dz);
        if (h_chk) begin
          check("hi", bus.hi, h_hi);
          check("lo", bus.lo, h_lo);
        end
      end
    end
  end

  task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int lit_lat, input logic [31:0] lit_hi,
                        input logic [31:0] lit_lo, input logic lit_dz,
                        input bit lit_vals, input bit inject);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    model(op, a, b, m_hi, m_lo, m_dz, m_chk, m_lat);
    m_acc = cyc;
    m_act = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    for (int i = 1; i < lit_lat; i++) begin
      @(negedge clk);
      if (inject && i == 4) begin
        bus.start = 1'b1;
        bus.op    = OpMultu;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end
      if (inject && i == 8) bus.start = 1'b0;
    end
    checkb("lit_done", bus.done, 1'b1);
    checkb("lit_dz", bus.dz, lit_dz);
    if (lit_vals) begin
      check("lit_hi", bus.hi, lit_hi);
      check("lit_lo", bus.lo, lit_lo);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OpMultu;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    checkb("rst_busy", bus.busy, 1'b0);
    checkb("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    checkb("rst_dz", bus.dz, 1'b0);
    rst = 1'b0;

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, 0);
    run_op(OpMult,  32'hFFFF_FFFD, 32'd7,         37, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1, 0);
    run_op(OpDivu,  32'd100,       32'd7,         33, 32'h0000_0002, 32'h0000_000E, 1'b0, 1, 0);
    run_op(OpDiv,   32'hFFFF_FF9C, 32'd7,         37, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1, 0);
`ifdef MULDIV_DZ_FAST_EN
    run_op(OpDivu,  32'h1234_5678, 32'd0,          1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op(OpDiv,   32'hFFFF_FFFB, 32'd0,          1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1, 0);
`else
    run_op(OpDivu,  32'h1234_5678, 32'd0,         33, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op(OpDiv,   32'hFFFF_FFFB, 32'd0,         37, 32'h0,         32'h0,         1'b1, 0, 0);
`endif
    run_op(OpMultu, 32'd3,         32'd5,         33, 32'h0,         32'd15,        1'b0, 1, 1);
    run_op(OpMult,  32'h8000_0000, 32'h8000_0000, 37, 32'h4000_0000, 32'h0,         1'b0, 1, 0);
    run_op(OpMult,  32'd5,         32'hFFFF_FFFF, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1, 0);
    run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 37, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1, 0);

    // Abort an op with reset partway through ITER.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMultu;
    bus.a     = 32'h0000_1234;
    bus.b     = 32'h0000_5678;
    model(OpMultu, 32'h0000_1234, 32'h0000_5678, m_hi, m_lo, m_dz, m_chk, m_lat);
    m_acc = cyc;
    m_act = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkb("abort_busy", bus.busy, 1'b0);
    checkb("abort_done", bus.done, 1'b0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    repeat (40) @(negedge clk);

    run_op(OpDivu, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
